// File: rtl/ahbl_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB3 bridge: transfer codes, sizes and FSM states.
package ahbl_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_t;

endpackage

// File: rtl/ahbl_apb3_watchdog.sv
// PREADY watchdog: counts stalled ACCESS cycles and flags the cycle that reaches TIMEOUT.
module ahbl_apb3_watchdog
   import ahbl_apb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_in;
         assign unused_in = clk ^ rst ^ clr ^ en;
         assign expired   = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
         logic [CW-1:0] cnt;

         // Saturates rather than wraps so a stuck count can never look fresh.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                       cnt <= '0;
            else if (clr)                  cnt <= '0;
            else if (en && cnt != LIMIT)   cnt <= cnt + 1'b1;
         end

         // Fires on the stalled cycle whose increment reaches TIMEOUT.
         assign expired = en && (cnt >= LIMIT - 1'b1);
      end
   endgenerate

endmodule

// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge with slot mask, word-only writes and PREADY watchdog.
module ahbl_apb3_bridge
   import ahbl_apb_pkg::*;
#(
   parameter int          PADDR_WIDTH = 12,
   parameter logic [15:0] SLOT_MASK   = 16'hFFFF,
   parameter int          TIMEOUT     = 255
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   HSEL,
   input  logic [31:0]            HADDR,
   input  logic [1:0]             HTRANS,
   input  logic                   HWRITE,
   input  logic [2:0]             HSIZE,
   input  logic [31:0]            HWDATA,
   input  logic                   HREADY,
   output logic                   HREADYOUT,
   output logic                   HRESP,
   output logic [31:0]            HRDATA,
   output logic [15:0]            PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [PADDR_WIDTH-1:0] PADDR,
   output logic [31:0]            PWDATA,
   input  logic [31:0]            PRDATA,
   input  logic                   PREADY,
   input  logic                   PSLVERR
);

   state_t     state;
   logic [3:0] slot_in;
   logic       accept, legal, start, reject;
   logic       wd_en, wd_expired;
   logic       unused_ok;

   assign slot_in = HADDR[PADDR_WIDTH+3:PADDR_WIDTH];
   assign accept  = HSEL && HTRANS[1] && HREADY && (state == ST_IDLE || state == ST_DONE);
   assign legal   = SLOT_MASK[slot_in] && (!HWRITE || HSIZE == HSIZE_WORD);
   assign start   = accept && legal;
   assign reject  = accept && !legal;
   assign wd_en   = (state == ST_ACCESS) && !PREADY;

   // Master holds HWDATA while HREADYOUT is low, so no capture is needed.
   assign PWDATA    = HWDATA;
   assign unused_ok = ^{HADDR[31:PADDR_WIDTH+4], HTRANS[0]};

   ahbl_apb3_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (HCLK),
      .rst     (HRESET),
      .clr     (start),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               state     <= ST_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
               if (start) begin
                  state     <= ST_SETUP;
                  HREADYOUT <= 1'b0;
                  PSEL      <= 16'(1) << slot_in;
                  PADDR     <= HADDR[PADDR_WIDTH-1:0];
                  PWRITE    <= HWRITE;
               end else if (reject) begin
                  state     <= ST_ERR1;
                  HREADYOUT <= 1'b0;
                  HRESP     <= 1'b1;
               end
            end
            ST_SETUP: begin
               state   <= ST_ACCESS;
               PENABLE <= 1'b1;
            end
            ST_ACCESS: begin
               if (PREADY || wd_expired) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
               end
               if (PREADY && !PSLVERR) begin
                  state     <= ST_DONE;
                  HREADYOUT <= 1'b1;
                  if (!PWRITE) HRDATA <= PRDATA;
               end else if (PREADY || wd_expired) begin
                  state <= ST_ERR1;
                  HRESP <= 1'b1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
            // A transfer offered here is the master cancelling after the error.
            ST_ERR2: begin
               state     <= ST_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
